dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Wait-state data-memory responder for the single-cycle CPU's load/store path.
//  It is the memory end of a req/ready handshake. It accepts one word access
//  from the requester, inserts a programmable number of wait states, then
//  returns read data or commits write data.
//  It sits between the CPU datapath and the data store, so multi-cycle
//  memory timing can be modelled and verified.
// PARAMETERS
//  DEPTH_WORDS  64  number of 32-bit words in data_memory (word index 0..DEPTH_WORDS-1)
//  ADDR_WIDTH   32  width of byte address input
//  WAIT_STATES  2   idle cycles between request acceptance and response (0..15)
// PORTS
//  clock   in   1           rising-edge clock
//  reset   in   1           asynchronous, active-low reset
//  req     in   1           requester asserts to start an access; held until ready
//  we      in   1           1 = store, 0 = load; sampled at acceptance
//  addr    in   ADDR_WIDTH  byte address; sampled at acceptance
//  wdata   in   32          store data; sampled at acceptance
//  ready   out  1           one-cycle pulse: access complete
//  rdata   out  32          load data; valid only while ready=1
//  err     out  1           with ready: access rejected (misaligned or out of range)
// BEHAVIOUR
//  - Storage: reg [31:0] data_memory[0:DEPTH_WORDS-1].
//    Word index = addr[ADDR_WIDTH-1:2]. Contents are NOT cleared by reset,
//    so benches may preload them hierarchically.
//  - Reset (reset=0, async): state=IDLE, wait counter=0, ready=0, rdata=0, err=0.
//    Takes effect immediately, including mid-access.
//  - FSM states IDLE, WAIT, RESP:
//    IDLE: on a rising edge with req=1, latch we/addr/wdata.
//      Go to WAIT with count=WAIT_STATES-1, or directly to RESP if WAIT_STATES=0.
//    WAIT: decrement count each cycle. When count reaches 0, go to RESP on the next edge.
//    RESP: ready=1, err and rdata as below, for exactly one cycle. Then go to IDLE.
//  - Latency: ready is high in the cycle that starts WAIT_STATES+1 edges after the accepting edge.
//  - Bad access: latched addr[1:0]!=0, or word index >= DEPTH_WORDS.
//    Response is err=1 with ready=1, rdata=0, and no write.
//  - Store: data_memory[index] <= latched wdata on the edge entering RESP (good access only).
//    rdata=0 for stores.
//  - Load: rdata = data_memory[index], registered on the edge entering RESP.
//  - Inputs are ignored outside IDLE. Deasserting req in WAIT does not cancel the access.
//    Changing addr/we/wdata in WAIT has no effect.
//  - Back-to-back: RESP always returns to IDLE. If req is still 1 in that IDLE cycle,
//    a new access is accepted; ready is never high on two consecutive cycles.
//  - Reset asserted during WAIT: the access is aborted, no write occurs, and no ready is issued.
//  - ready, rdata and err are all registered outputs. No combinational path from inputs to outputs.
// TESTING
//  1. Preload data_memory[1]=1234. Issue load from addr 4 with WAIT_STATES=2.
//     -> ready=1 for one cycle, 3 edges after acceptance; rdata=1234, err=0.
//  2. Store 3917 to addr 12, then load from addr 12.
//     -> data_memory[3]=3917; the second ready returns rdata=3917.
//  3. Load from addr 6 (misaligned) and from addr 256 (index 64 >= DEPTH).
//     -> each gets ready=1, err=1, rdata=0; memory unchanged.
//  4. Store 55 to addr 16, then pull reset low during WAIT.
//     -> ready stays 0, data_memory[4] keeps its old value, state=IDLE after release.
//  5. Hold req=1 with loads from addr 4 then addr 8; DM[1]=1234, DM[2]=2683.
//     -> two single-cycle ready pulses with at least one low cycle between them;
//        rdata 1234 then 2683.
//  6. WAIT_STATES=0 instance: load from addr 4.
//     -> ready on the cycle after the accepting edge; rdata=1234.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU load/store path and the data-memory responder.
// The requester drives req/we/addr/wdata; the responder drives ready/rdata/err.
interface dmem_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  ready;
  logic [31:0]           rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: accepts one word access, stalls for WAIT_STATES
// cycles, commits the store or fetches the load, then pulses ready for one cycle.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input logic             clock,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  logic [31:0] data_memory [0:DEPTH_WORDS-1];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rspData_q;
  logic                  rspErr_q;
  logic                  ready_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic                  accWe;
  logic [ADDR_WIDTH-1:0] accAddr;
  logic [31:0]           accWdata;
  logic                  accBad;
  logic [IDX_W-1:0]      accIdx;
  logic                  enterResp;
  logic                  memWe;
  logic [31:0]           loadData;

  // With zero wait states the access enters RESP straight from IDLE, so the live
  // bus fields are used; otherwise the fields latched at acceptance apply.
  assign accWe    = (state_q == IDLE) ? bus.we    : we_q;
  assign accAddr  = (state_q == IDLE) ? bus.addr  : addr_q;
  assign accWdata = (state_q == IDLE) ? bus.wdata : wdata_q;
  assign accBad   = (accAddr[1:0] != 2'b00) || ({2'b00, accAddr[ADDR_WIDTH-1:2]} >= DEPTH_A);
  assign accIdx   = accAddr[IDX_W+1:2];
  assign memWe    = enterResp && accWe && !accBad && reset;
  assign loadData = (!accWe && !accBad) ? data_memory[accIdx] : 32'd0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    enterResp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (WAIT_STATES == 0) begin
            state_d   = RESP;
            enterResp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          enterResp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The response is captured when RESP is entered and presented on the outputs one
  // edge later, so ready/rdata/err come straight from flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      rspData_q <= 32'd0;
      rspErr_q  <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (enterResp) begin
        rspData_q <= loadData;
        rspErr_q  <= accBad;
      end
      ready_q <= (state_q == RESP);
      rdata_q <= (state_q == RESP) ? rspData_q : 32'd0;
      err_q   <= (state_q == RESP) && rspErr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (memWe) begin
      data_memory[accIdx] <= accWdata;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vectors, multi-cycle corner sequences and
// random accesses compared against a word-array model of the data memory.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int AW    = 32;
  localparam int WS    = 2;

  logic clock = 1'b0;
  logic reset;
  int   asserts  = 0;
  int   failures = 0;

  logic [31:0] model [0:DEPTH-1];

  always #5 clock = ~clock;

  dmem_responder_if #(.ADDR_WIDTH(AW)) bus2 ();
  dmem_responder_if #(.ADDR_WIDTH(AW)) bus0 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus2)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .clock(clock),
    .reset(reset),
    .bus  (bus0)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    bit          expErr;
  } vec_t;

  vec_t vecs [7];

  // Reference rule: a word access is legal when aligned and inside the array.
  function automatic void modelAccess(input bit we, input logic [31:0] addr,
                                      input logic [31:0] wdata,
                                      output logic [31:0] rd, output logic e);
    int idx;
    idx = int'(addr >> 2);
    e   = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
    rd  = 32'd0;
    if (!e) begin
      if (we) model[idx] = wdata;
      else    rd = model[idx];
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               output int lat, output logic [31:0] rd, output logic e);
    @(negedge clock);
    bus2.req   = 1'b1;
    bus2.we    = we;
    bus2.addr  = addr;
    bus2.wdata = wdata;
    @(posedge clock);
    #1;
    bus2.req   = 1'b0;
    bus2.we    = ~we;
    bus2.addr  = $urandom;
    bus2.wdata = $urandom;
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (bus2.ready !== 1'b1 && lat < 20);
    rd = bus2.rdata;
    e  = bus2.err;
    @(posedge clock);
    #1;
    checkOutput("readyPulse", {31'd0, bus2.ready}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] rd, expRd;
    logic        e, expE;
    int          mism;
    int          first, second, cyc;
    logic [31:0] r1, r2;
    bit          seenReady;
    bit          we;
    logic [31:0] addr, wdata;
    int          kind;

    for (int i = 0; i < DEPTH; i++) model[i] = $urandom;
    model[1]  = 32'd1234;
    model[2]  = 32'd2683;
    model[4]  = 32'd999;
    model[63] = 32'hCAFEF00D;
    for (int i = 0; i < DEPTH; i++) begin
      dut.data_memory[i]  = model[i];
      dut0.data_memory[i] = model[i];
    end

    vecs[0] = '{1'b0, 32'd4,   32'd0,    32'd1234,      1'b0};
    vecs[1] = '{1'b1, 32'd12,  32'd3917, 32'd0,         1'b0};
    vecs[2] = '{1'b0, 32'd12,  32'd0,    32'd3917,      1'b0};
    vecs[3] = '{1'b0, 32'd6,   32'd0,    32'd0,         1'b1};
    vecs[4] = '{1'b0, 32'd256, 32'd0,    32'd0,         1'b1};
    vecs[5] = '{1'b1, 32'd10,  32'd777,  32'd0,         1'b1};
    vecs[6] = '{1'b0, 32'd252, 32'd0,    32'hCAFEF00D,  1'b0};

    bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    checkOutput("rstReady", {31'd0, bus2.ready}, 32'd0);
    checkOutput("rstRdata", bus2.rdata, 32'd0);
    checkOutput("rstErr", {31'd0, bus2.err}, 32'd0);
    checkOutput("rstReady0", {31'd0, bus0.ready}, 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      modelAccess(vecs[i].we, vecs[i].addr, vecs[i].wdata, expRd, expE);
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, e);
      checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].expErr});
      checkOutput($sformatf("vec%0d_latency", i), lat, WS + 1);
    end
    checkOutput("storeCommitted", dut.data_memory[3], 32'd3917);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.data_memory[i] !== model[i]) mism++;
    checkOutput("memMatchAfterTable", mism, 0);

    // Store aborted by reset while still waiting: no write, no ready.
    @(negedge clock);
    bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'd16; bus2.wdata = 32'd55;
    @(posedge clock);
    #1 bus2.req = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    seenReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      if (bus2.ready !== 1'b0) seenReady = 1'b1;
    end
    checkOutput("abortNoReady", {31'd0, seenReady}, 32'd0);
    checkOutput("abortRdata", bus2.rdata, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    checkOutput("abortNoWrite", dut.data_memory[4], model[4]);
    modelAccess(1'b0, 32'd16, 32'd0, expRd, expE);
    applyStimulus(1'b0, 32'd16, 32'd0, lat, rd, e);
    checkOutput("afterAbortRdata", rd, expRd);
    checkOutput("afterAbortLatency", lat, WS + 1);

    // Back-to-back loads with req held high throughout.
    @(negedge clock);
    bus2.req = 1'b1; bus2.we = 1'b0; bus2.addr = 32'd4; bus2.wdata = 32'd0;
    @(posedge clock);
    first = -1; second = -1; cyc = 0; r1 = 0; r2 = 0;
    while (second < 0 && cyc < 30) begin
      @(posedge clock);
      #1;
      cyc++;
      if (bus2.ready === 1'b1) begin
        if (first < 0) begin
          first = cyc; r1 = bus2.rdata; bus2.addr = 32'd8;
        end else begin
          second = cyc; r2 = bus2.rdata; bus2.req = 1'b0;
        end
      end
    end
    @(posedge clock);
    #1;
    checkOutput("b2bFirstLatency", first, WS + 1);
    checkOutput("b2bFirstRdata", r1, model[1]);
    checkOutput("b2bSpacing", second - first, WS + 2);
    checkOutput("b2bSecondRdata", r2, model[2]);
    checkOutput("b2bReadyLow", {31'd0, bus2.ready}, 32'd0);

    // Zero-wait-state instance answers one edge after acceptance.
    @(negedge clock);
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'd4;
    @(posedge clock);
    #1 bus0.req = 1'b0;
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (bus0.ready !== 1'b1 && lat < 20);
    checkOutput("ws0Latency", lat, 1);
    checkOutput("ws0Rdata", bus0.rdata, 32'd1234);
    checkOutput("ws0Err", {31'd0, bus0.err}, 32'd0);

    for (int n = 0; n < 150; n++) begin
      we    = 1'($urandom_range(0, 1));
      kind  = int'($urandom_range(0, 9));
      wdata = $urandom;
      if (kind == 0)      addr = {24'd0, 2'($urandom_range(0, 63)), 6'd0} | 32'($urandom_range(1, 3)) | (32'($urandom_range(0, 63)) << 2);
      else if (kind == 1) addr = ($urandom | 32'h100) & 32'hFFFF_FFFC;
      else                addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      modelAccess(we, addr, wdata, expRd, expE);
      applyStimulus(we, addr, wdata, lat, rd, e);
      checkOutput($sformatf("rand%0d_rdata", n), rd, expRd);
      checkOutput($sformatf("rand%0d_err", n), {31'd0, e}, {31'd0, expE});
      checkOutput($sformatf("rand%0d_latency", n), lat, WS + 1);
    end
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.data_memory[i] !== model[i]) mism++;
    checkOutput("memMatchAfterRandom", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
